// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 raster and screen-window constants shared by the scanout blocks
package vga_timing_pkg;
  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FRONT = 16;
  localparam int VGA_H_SYNC = 96;
  localparam int VGA_H_BACK = 48;
  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FRONT = 10;
  localparam int VGA_V_SYNC = 2;
  localparam int VGA_V_BACK = 33;
  localparam int VGA_X_OFFSET = 64;
  localparam int VGA_Y_OFFSET = 112;
  localparam int VGA_SCREEN_WORDS = 32;
  localparam int VGA_SCREEN_ROWS = 256;
  localparam logic SYNC_ACTIVE = 1'b0;
  function automatic logic in_range(int x, int lo, int n);
    return x >= lo && x < lo + n;
  endfunction
endpackage

// File: rtl/vga_scanout_if.sv
// vga_scanout_if: pixel-side read port of the video RAM
interface vga_scanout_if;
  logic        p_read;
  logic [12:0] p_addr;
  logic [15:0] p_dout;
  modport master(output p_read, output p_addr, input p_dout);
  modport slave(input p_read, input p_addr, output p_dout);
endinterface

// File: rtl/vga_timing.sv
// vga_timing: raster counters with registered sync, visible and frame-start flags
module vga_timing
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = VGA_H_VISIBLE,
  parameter int H_FRONT = VGA_H_FRONT,
  parameter int H_SYNC = VGA_H_SYNC,
  parameter int H_BACK = VGA_H_BACK,
  parameter int V_VISIBLE = VGA_V_VISIBLE,
  parameter int V_FRONT = VGA_V_FRONT,
  parameter int V_SYNC = VGA_V_SYNC,
  parameter int V_BACK = VGA_V_BACK,
  parameter int X_OFFSET = VGA_X_OFFSET,
  parameter int Y_OFFSET = VGA_Y_OFFSET,
  parameter int SCREEN_WORDS = VGA_SCREEN_WORDS,
  parameter int SCREEN_ROWS = VGA_SCREEN_ROWS
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] hnext_o,
  output logic [9:0] vnext_o,
  output logic       win_o,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic       active_o,
  output logic       frame_start_o
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  logic [9:0] hcount_q, hcount_d, vcount_q, vcount_d;
  logic hsync_q, vsync_q, active_q, frame_start_q;
  int h, v;
  always_comb begin
    h = int'(hcount_q);
    v = int'(vcount_q);
    hcount_d = h == H_TOTAL - 1 ? '0 : hcount_q + 10'd1;
    vcount_d = h != H_TOTAL - 1 ? vcount_q : v == V_TOTAL - 1 ? '0 : vcount_q + 10'd1;
    win_o = in_range(h, X_OFFSET, SCREEN_WORDS * 16) && in_range(v, Y_OFFSET, SCREEN_ROWS);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      hcount_q <= '0;
      vcount_q <= '0;
      hsync_q <= ~SYNC_ACTIVE;
      vsync_q <= ~SYNC_ACTIVE;
      active_q <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      hsync_q <= in_range(h, H_VISIBLE + H_FRONT, H_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync_q <= in_range(v, V_VISIBLE + V_FRONT, V_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      active_q <= h < H_VISIBLE && v < V_VISIBLE;
      frame_start_q <= h == 0 && v == 0;
    end
  assign hnext_o = hcount_d;
  assign vnext_o = vcount_d;
  assign hsync_o = hsync_q;
  assign vsync_o = vsync_q;
  assign active_o = active_q;
  assign frame_start_o = frame_start_q;
endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: VGA raster with centred 512x256 monochrome window fetched word-by-word from video RAM
module vga_scanout
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = VGA_H_VISIBLE,
  parameter int H_FRONT = VGA_H_FRONT,
  parameter int H_SYNC = VGA_H_SYNC,
  parameter int H_BACK = VGA_H_BACK,
  parameter int V_VISIBLE = VGA_V_VISIBLE,
  parameter int V_FRONT = VGA_V_FRONT,
  parameter int V_SYNC = VGA_V_SYNC,
  parameter int V_BACK = VGA_V_BACK,
  parameter int X_OFFSET = VGA_X_OFFSET,
  parameter int Y_OFFSET = VGA_Y_OFFSET,
  parameter int SCREEN_WORDS = VGA_SCREEN_WORDS,
  parameter int SCREEN_ROWS = VGA_SCREEN_ROWS
) (
  input  logic             clk,
  input  logic             reset,
  vga_scanout_if.master    ram,
  output logic             hsync,
  output logic             vsync,
  output logic             active,
  output logic             pixel,
  output logic             frame_start
);
  logic [9:0] hnext, vnext;
  logic win, p_read_q, p_read_d, pixel_q, pixel_d;
  logic [12:0] p_addr_q, p_addr_d;
  logic [2:0] pipe_q;
  logic [15:0] shift_q, shift_d;
  int hn, vn, fo;
  vga_timing #(
    .H_VISIBLE(H_VISIBLE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_VISIBLE(V_VISIBLE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK),
    .X_OFFSET(X_OFFSET), .Y_OFFSET(Y_OFFSET), .SCREEN_WORDS(SCREEN_WORDS), .SCREEN_ROWS(SCREEN_ROWS)
  ) u_timing (
    .clk(clk), .reset(reset), .hnext_o(hnext), .vnext_o(vnext), .win_o(win),
    .hsync_o(hsync), .vsync_o(vsync), .active_o(active), .frame_start_o(frame_start)
  );
  // fetch is decided on next-cycle counters so p_read itself can be a flop
  always_comb begin
    hn = int'(hnext);
    vn = int'(vnext);
    fo = hn - (X_OFFSET - 4);
    p_read_d = in_range(vn, Y_OFFSET, SCREEN_ROWS) && in_range(fo, 0, SCREEN_WORDS * 16) && fo % 16 == 0;
    p_addr_d = p_read_d ? 13'((vn - Y_OFFSET) * SCREEN_WORDS + fo / 16) : '0;
    shift_d = pipe_q[2] ? ram.p_dout : win ? {1'b0, shift_q[15:1]} : shift_q;
    pixel_d = win && shift_q[0];
  end
  // pipe_q tracks the 3-cycle RAM latency; clearing it on reset drops in-flight words
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      p_read_q <= 1'b0;
      p_addr_q <= '0;
      pipe_q <= '0;
      shift_q <= '0;
      pixel_q <= 1'b0;
    end else begin
      p_read_q <= p_read_d;
      p_addr_q <= p_addr_d;
      pipe_q <= {pipe_q[1:0], p_read_q};
      shift_q <= shift_d;
      pixel_q <= pixel_d;
    end
  assign ram.p_read = p_read_q;
  assign ram.p_addr = p_addr_q;
  assign pixel = pixel_q;
endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: reduced-raster and default-raster scanout checked per cycle against a cycle-count model
module tb_vga_scanout;
  typedef struct {int hv, hf, hs, hb, vv, vf, vs, vb, xo, yo, sw, sr;} cfg_t;
  typedef struct packed {logic hs, vs, act, pix, fs, rd; logic [12:0] addr;} out_t;
  localparam int HV = 96, HF = 4, HS = 8, HB = 4, VV = 14, VF = 2, VS = 2, VB = 2;
  localparam int XO = 8, YO = 3, SW = 4, SR = 8;
  localparam int FT = (HV + HF + HS + HB) * (VV + VF + VS + VB);
  logic clk = 1'b0, reset = 1'b1;
  logic s_hs, s_vs, s_act, s_pix, s_fs, d_hs, d_vs, d_act, d_pix, d_fs;
  logic [15:0] mem [8192];
  logic [15:0] d1, d2, d3;
  cfg_t sc, dc;
  int n, errors, checks, rd_cnt, pix_cnt, fs_cnt, ones;
  vga_scanout_if ifs();
  vga_scanout_if ifd();
  vga_scanout #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .X_OFFSET(XO), .Y_OFFSET(YO), .SCREEN_WORDS(SW), .SCREEN_ROWS(SR)
  ) dut (
    .clk(clk), .reset(reset), .ram(ifs), .hsync(s_hs), .vsync(s_vs),
    .active(s_act), .pixel(s_pix), .frame_start(s_fs)
  );
  vga_scanout dut_dflt (
    .clk(clk), .reset(reset), .ram(ifd), .hsync(d_hs), .vsync(d_vs),
    .active(d_act), .pixel(d_pix), .frame_start(d_fs)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    d1 <= mem[ifs.p_addr];
    d2 <= d1;
    d3 <= d2;
  end
  assign ifs.p_dout = d3;
  assign ifd.p_dout = '0;

  // expected outputs n cycles after reset release, from raster arithmetic on the cycle count
  function automatic out_t model(cfg_t g, int cyc);
    out_t e;
    int ht, vt, h, v, ph, pv, c, r, fo;
    logic w;
    e = '0;
    e.hs = 1'b1;
    e.vs = 1'b1;
    if (cyc == 0) return e;
    ht = g.hv + g.hf + g.hs + g.hb;
    vt = g.vv + g.vf + g.vs + g.vb;
    h = cyc % ht;
    v = (cyc / ht) % vt;
    ph = (cyc - 1) % ht;
    pv = ((cyc - 1) / ht) % vt;
    c = ph - g.xo;
    r = pv - g.yo;
    fo = h - (g.xo - 4);
    w = c >= 0 && c < 16 * g.sw && r >= 0 && r < g.sr;
    e.hs = !(ph >= g.hv + g.hf && ph < g.hv + g.hf + g.hs);
    e.vs = !(pv >= g.vv + g.vf && pv < g.vv + g.vf + g.vs);
    e.act = ph < g.hv && pv < g.vv;
    if (w) e.pix = mem[r * g.sw + c / 16][c % 16];
    e.fs = ph == 0 && pv == 0;
    e.rd = v >= g.yo && v < g.yo + g.sr && fo >= 0 && fo < 16 * g.sw && fo % 16 == 0;
    if (e.rd) e.addr = 13'((v - g.yo) * g.sw + fo / 16);
    return e;
  endfunction

  task automatic cmp(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s n=%0d got=%0h expected=%0h", name, n, got, exp);
    end
  endtask

  task automatic check(string tag, out_t o, out_t e);
    cmp({tag, ".hsync"}, 32'(o.hs), 32'(e.hs));
    cmp({tag, ".vsync"}, 32'(o.vs), 32'(e.vs));
    cmp({tag, ".active"}, 32'(o.act), 32'(e.act));
    cmp({tag, ".pixel"}, 32'(o.pix), 32'(e.pix));
    cmp({tag, ".frame_start"}, 32'(o.fs), 32'(e.fs));
    cmp({tag, ".p_read"}, 32'(o.rd), 32'(e.rd));
    if (e.rd || n == 0) cmp({tag, ".p_addr"}, 32'(o.addr), 32'(e.addr));
  endtask

  task automatic sample();
    out_t os, od;
    os = {s_hs, s_vs, s_act, s_pix, s_fs, ifs.p_read, ifs.p_addr};
    od = {d_hs, d_vs, d_act, d_pix, d_fs, ifd.p_read, ifd.p_addr};
    check("small", os, model(sc, n));
    check("default", od, model(dc, n));
    rd_cnt += int'(ifs.p_read);
    pix_cnt += int'(s_pix);
    fs_cnt += int'(s_fs);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    n++;
    sample();
  endtask

  task automatic restart();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    rd_cnt = 0;
    pix_cnt = 0;
    fs_cnt = 0;
    #1 sample();
  endtask

  task automatic fill(int mode);
    ones = 0;
    for (int i = 0; i < 8192; i++) begin
      mem[i] = mode == 0 ? 16'(i) : mode == 1 ? 16'h0 : mode == 2 ? 16'hFFFF : 16'($urandom);
      if (i < SW * SR) ones += $countones(mem[i]);
    end
  endtask

  initial begin
    sc = '{HV, HF, HS, HB, VV, VF, VS, VB, XO, YO, SW, SR};
    dc = '{640, 16, 96, 48, 480, 10, 2, 33, 64, 112, 32, 256};
    errors = 0;
    checks = 0;
    fill(0);
    restart();
    while (n < FT + 2) step();
    cmp("p_read_per_frame", 32'(rd_cnt), 32'(SW * SR));
    cmp("frame_start_count", 32'(fs_cnt), 32'd2);
    fill(1);
    mem[0] = 16'h0001;
    restart();
    while (n < FT) step();
    cmp("pixel_count_col0", 32'(pix_cnt), 32'd1);
    fill(1);
    mem[SW - 1] = 16'h8000;
    restart();
    while (n < FT) step();
    cmp("pixel_count_lastcol", 32'(pix_cnt), 32'd1);
    fill(2);
    restart();
    while (n < FT) step();
    cmp("pixel_count_full", 32'(pix_cnt), 32'(SW * SR * 16));
    fill(3);
    restart();
    while (n < FT) step();
    cmp("pixel_count_random", 32'(pix_cnt), 32'(ones));
    fill(3);
    restart();
    while (n < 5 * (HV + HF + HS + HB) + 40) step();
    #2 reset = 1'b1;
    n = 0;
    #1 sample();
    restart();
    while (n < FT) step();
    cmp("p_read_after_reset", 32'(rd_cnt), 32'(SW * SR));
    cmp("pixel_count_after_reset", 32'(pix_cnt), 32'(ones));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
